// File: rtl/cache_nway.sv
// Direct-mapped or 2-way set-associative write-through read cache.
// Read hits return data in the same cycle. Read misses fetch a full line. Writes always go to the backing store.
module cache_nway #(
    parameter int SETS       = 64,
    parameter int WAYS       = 2,
    parameter int LINE_WORDS = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    rd_en,
    input  logic                    wr_en,
    input  logic [31:0]             addr,
    input  logic [31:0]             wdata,
    output logic [31:0]             rdata,
    output logic                    ready,
    output logic                    mem_rd_en,
    output logic                    mem_wr_en,
    output logic [31:0]             mem_addr,
    output logic [31:0]             mem_wdata,
    input  logic [32*LINE_WORDS-1:0] mem_rdata,
    input  logic                    mem_ready,
    output logic [15:0]             hit_cnt,
    output logic [15:0]             miss_cnt
);

    localparam int OFF_W  = $clog2(LINE_WORDS);
    localparam int OFF_B  = (OFF_W > 0) ? OFF_W : 1;
    localparam int IDX_W  = $clog2(SETS);
    localparam int TAG_W  = 30 - OFF_W - IDX_W;
    localparam int LINE_W = 32 * LINE_WORDS;
    localparam logic [31:0] LINE_MASK = ~((32'd1 << (OFF_W + 2)) - 32'd1);

    typedef enum logic [1:0] {IDLE, RD_MISS, WR_THRU} state_t;

    state_t state, state_nx;

    logic [SETS-1:0]   valid   [WAYS];
    logic [SETS-1:0]   lru;
    logic [TAG_W-1:0]  tag_mem [WAYS][SETS];
    logic [LINE_W-1:0] data_mem[WAYS][SETS];

    logic [OFF_B-1:0] word_off;
    logic [IDX_W-1:0] idx;
    logic [TAG_W-1:0] tag;
    logic             hit;
    logic             hit_way;
    logic             victim;
    logic [31:0]      hit_word;
    logic [31:0]      fill_word;
    logic             hit_inc, miss_inc, fill_en, wr_upd;

    // Byte-lane bits carry no meaning in a word-granular cache.
    logic unused_byte_bits;
    assign unused_byte_bits = ^addr[1:0];

    assign word_off = (OFF_W > 0) ? addr[2 +: OFF_B] : '0;
    assign idx      = addr[2 + OFF_W +: IDX_W];
    assign tag      = addr[31 -: TAG_W];

    // NOTE: every output of a combinational block gets a default first so no latch is inferred.
    always_comb begin
        hit     = 1'b0;
        hit_way = 1'b0;
        for (int w = 0; w < WAYS; w++) begin
            if (valid[w][idx] && tag_mem[w][idx] == tag) begin
                hit     = 1'b1;
                hit_way = 1'(w);
            end
        end
    end

    // Scan downward so the lowest-numbered invalid way wins; fall back to LRU.
    always_comb begin
        victim = (WAYS > 1) ? lru[idx] : 1'b0;
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (!valid[w][idx]) victim = 1'(w);
        end
    end

    assign hit_word  = data_mem[hit_way][idx][{word_off, 5'b0} +: 32];
    assign fill_word = mem_rdata[{word_off, 5'b0} +: 32];

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    // NOTE: combinational logic uses blocking assignments; clocked state uses non-blocking only.
    always_comb begin
        state_nx  = state;
        ready     = 1'b1;
        rdata     = '0;
        mem_rd_en = 1'b0;
        mem_wr_en = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        hit_inc   = 1'b0;
        miss_inc  = 1'b0;
        fill_en   = 1'b0;
        wr_upd    = 1'b0;
        case (state)
            IDLE: begin
                if (wr_en) begin
                    ready    = 1'b0;
                    state_nx = WR_THRU;
                end else if (rd_en) begin
                    if (hit) begin
                        rdata   = hit_word;
                        hit_inc = 1'b1;
                    end else begin
                        ready    = 1'b0;
                        miss_inc = 1'b1;
                        state_nx = RD_MISS;
                    end
                end
            end
            RD_MISS: begin
                mem_rd_en = 1'b1;
                mem_addr  = addr & LINE_MASK;
                ready     = mem_ready;
                if (mem_ready) begin
                    rdata    = fill_word;
                    fill_en  = 1'b1;
                    state_nx = IDLE;
                end
            end
            WR_THRU: begin
                mem_wr_en = 1'b1;
                mem_addr  = addr;
                mem_wdata = wdata;
                ready     = mem_ready;
                if (mem_ready) begin
                    wr_upd   = hit;
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int w = 0; w < WAYS; w++) valid[w] <= '0;
            lru <= '0;
        end else if (fill_en) begin
            valid[victim][idx] <= 1'b1;
            lru[idx]           <= ~victim;
        end else if (wr_upd || hit_inc) begin
            lru[idx] <= ~hit_way;
        end
    end

    // NOTE: tag and data arrays are deliberately not reset; the valid bits alone qualify them.
    always_ff @(posedge clk) begin
        if (!rst && fill_en) begin
            tag_mem[victim][idx]  <= tag;
            data_mem[victim][idx] <= mem_rdata;
        end else if (!rst && wr_upd) begin
            data_mem[hit_way][idx][{word_off, 5'b0} +: 32] <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hit_cnt  <= '0;
            miss_cnt <= '0;
        end else begin
            if (hit_inc && hit_cnt != 16'hFFFF)   hit_cnt  <= hit_cnt + 16'd1;
            if (miss_inc && miss_cnt != 16'hFFFF) miss_cnt <= miss_cnt + 16'd1;
        end
    end

endmodule

// File: tb/tb_cache_nway.sv
// Self-checking bench for cache_nway.
// It has a per-cycle vector table plus directed sequences for LRU replacement, reset during a miss, the WAYS=1 configuration and counter saturation.
module tb_cache_nway;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        rd_en, wr_en;
    logic [31:0] addr, wdata, rdata, mem_addr, mem_wdata;
    logic        ready, mem_rd_en, mem_wr_en, mem_ready;
    logic [63:0] mem_rdata;
    logic [15:0] hit_cnt, miss_cnt;

    logic        u1_rd_en, u1_wr_en;
    logic [31:0] u1_addr, u1_wdata, u1_rdata, u1_mem_addr, u1_mem_wdata;
    logic        u1_ready, u1_mem_rd_en, u1_mem_wr_en, u1_mem_ready;
    logic [63:0] u1_mem_rdata;
    logic [15:0] u1_hit_cnt, u1_miss_cnt;

    cache_nway dut (
        .clk(clk), .rst(rst), .rd_en(rd_en), .wr_en(wr_en), .addr(addr), .wdata(wdata),
        .rdata(rdata), .ready(ready), .mem_rd_en(mem_rd_en), .mem_wr_en(mem_wr_en),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .mem_ready(mem_ready), .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
    );

    cache_nway #(.SETS(64), .WAYS(1), .LINE_WORDS(2)) dut1 (
        .clk(clk), .rst(rst), .rd_en(u1_rd_en), .wr_en(u1_wr_en), .addr(u1_addr),
        .wdata(u1_wdata), .rdata(u1_rdata), .ready(u1_ready), .mem_rd_en(u1_mem_rd_en),
        .mem_wr_en(u1_mem_wr_en), .mem_addr(u1_mem_addr), .mem_wdata(u1_mem_wdata),
        .mem_rdata(u1_mem_rdata), .mem_ready(u1_mem_ready), .hit_cnt(u1_hit_cnt),
        .miss_cnt(u1_miss_cnt)
    );

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [63:0] mk_line(input logic [31:0] base);
        return {32'hD000_0000 ^ (base + 32'd4), 32'hC000_0000 ^ base};
    endfunction

    typedef struct {
        logic        rd, wr;
        logic [31:0] a, wd;
        logic        mr;
        logic [63:0] ml;
        logic        e_ready;
        logic [31:0] e_rdata;
        logic        e_mrd, e_mwr;
        logic [31:0] e_maddr, e_mwdata;
        logic [15:0] e_hit, e_miss;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mkv(input logic rd, input logic wr, input logic [31:0] a,
                                 input logic [31:0] wd, input logic mr, input logic [63:0] ml,
                                 input logic e_ready, input logic [31:0] e_rdata,
                                 input logic e_mrd, input logic e_mwr, input logic [31:0] e_maddr,
                                 input logic [31:0] e_mwdata, input logic [15:0] e_hit,
                                 input logic [15:0] e_miss);
        vec_t v;
        v.rd = rd; v.wr = wr; v.a = a; v.wd = wd; v.mr = mr; v.ml = ml;
        v.e_ready = e_ready; v.e_rdata = e_rdata; v.e_mrd = e_mrd; v.e_mwr = e_mwr;
        v.e_maddr = e_maddr; v.e_mwdata = e_mwdata; v.e_hit = e_hit; v.e_miss = e_miss;
        return v;
    endfunction

    task automatic do_reset();
        rst = 1'b1; rd_en = 1'b0; wr_en = 1'b0; mem_ready = 1'b0;
        u1_rd_en = 1'b0; u1_mem_ready = 1'b0;
        repeat (2) step();
        rst = 1'b0;
    endtask

    // Complete one read on the 2-way DUT; on a miss the line is served as soon as mem_rd_en is seen.
    task automatic read_op(input logic [31:0] a, input bit exp_hit);
        logic [63:0] line;
        logic [31:0] base, word;
        base = a & 32'hFFFF_FFF8;
        line = mk_line(base);
        word = a[2] ? line[63:32] : line[31:0];
        rd_en = 1'b1; wr_en = 1'b0; addr = a; mem_rdata = line; mem_ready = 1'b0;
        @(negedge clk);
        if (exp_hit) begin
            check($sformatf("hit_ready_%08h", a), {31'd0, ready}, 32'd1);
            check($sformatf("hit_rdata_%08h", a), rdata, word);
            step();
        end else begin
            check($sformatf("miss_stall_%08h", a), {31'd0, ready}, 32'd0);
            step();
            @(negedge clk);
            check($sformatf("miss_mem_rd_%08h", a), {31'd0, mem_rd_en}, 32'd1);
            check($sformatf("miss_mem_addr_%08h", a), mem_addr, base);
            mem_ready = 1'b1;
            #1;
            check($sformatf("miss_ready_%08h", a), {31'd0, ready}, 32'd1);
            check($sformatf("miss_rdata_%08h", a), rdata, word);
            step();
        end
        rd_en = 1'b0; mem_ready = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    localparam logic [63:0] LA = 64'hBBBB_BBBB_AAAA_AAAA;
    localparam logic [63:0] LC = 64'hDDDD_DDDD_CCCC_CCCC;

    initial begin
        logic [31:0] u1_addrs [3];
        logic [63:0] l1;
        vec_t v;

        addr = '0; wdata = '0; mem_rdata = '0;
        u1_wr_en = 1'b0; u1_addr = '0; u1_wdata = '0; u1_mem_rdata = '0;
        do_reset();

        //                rd wr addr          wdata         mr ml    rdy rdata         mrd mwr maddr         mwdata        hit miss
        vecs.push_back(mkv(0, 0, 32'h0,       32'h0,        0, 64'h0, 1, 32'h0,        0, 0, 32'h0,       32'h0,        0, 0));
        vecs.push_back(mkv(1, 0, 32'h400,     32'h0,        0, LA,    0, 32'h0,        0, 0, 32'h0,       32'h0,        0, 0));
        vecs.push_back(mkv(1, 0, 32'h400,     32'h0,        0, LA,    0, 32'h0,        1, 0, 32'h400,     32'h0,        0, 1));
        vecs.push_back(mkv(1, 0, 32'h400,     32'h0,        0, LA,    0, 32'h0,        1, 0, 32'h400,     32'h0,        0, 1));
        vecs.push_back(mkv(1, 0, 32'h400,     32'h0,        0, LA,    0, 32'h0,        1, 0, 32'h400,     32'h0,        0, 1));
        vecs.push_back(mkv(1, 0, 32'h400,     32'h0,        1, LA,    1, 32'hAAAAAAAA, 1, 0, 32'h400,     32'h0,        0, 1));
        vecs.push_back(mkv(1, 0, 32'h404,     32'h0,        0, LA,    1, 32'hBBBBBBBB, 0, 0, 32'h0,       32'h0,        0, 1));
        vecs.push_back(mkv(0, 0, 32'h0,       32'h0,        1, LA,    1, 32'h0,        0, 0, 32'h0,       32'h0,        1, 1));
        vecs.push_back(mkv(0, 1, 32'h404,     32'h12345678, 0, 64'h0, 0, 32'h0,        0, 0, 32'h0,       32'h0,        1, 1));
        vecs.push_back(mkv(0, 1, 32'h404,     32'h12345678, 0, 64'h0, 0, 32'h0,        0, 1, 32'h404,     32'h12345678, 1, 1));
        vecs.push_back(mkv(0, 1, 32'h404,     32'h12345678, 1, 64'h0, 1, 32'h0,        0, 1, 32'h404,     32'h12345678, 1, 1));
        vecs.push_back(mkv(1, 0, 32'h404,     32'h0,        0, 64'h0, 1, 32'h12345678, 0, 0, 32'h0,       32'h0,        1, 1));
        vecs.push_back(mkv(0, 0, 32'h0,       32'h0,        1, 64'h0, 1, 32'h0,        0, 0, 32'h0,       32'h0,        2, 1));
        vecs.push_back(mkv(0, 1, 32'h800,     32'h0BAD0800, 0, 64'h0, 0, 32'h0,        0, 0, 32'h0,       32'h0,        2, 1));
        vecs.push_back(mkv(0, 1, 32'h800,     32'h0BAD0800, 1, 64'h0, 1, 32'h0,        0, 1, 32'h800,     32'h0BAD0800, 2, 1));
        vecs.push_back(mkv(1, 0, 32'h800,     32'h0,        0, LC,    0, 32'h0,        0, 0, 32'h0,       32'h0,        2, 1));
        vecs.push_back(mkv(1, 0, 32'h800,     32'h0,        1, LC,    1, 32'hCCCCCCCC, 1, 0, 32'h800,     32'h0,        2, 2));
        vecs.push_back(mkv(0, 0, 32'h0,       32'h0,        0, 64'h0, 1, 32'h0,        0, 0, 32'h0,       32'h0,        2, 2));
        vecs.push_back(mkv(1, 0, 32'h804,     32'h0,        0, 64'h0, 1, 32'hDDDDDDDD, 0, 0, 32'h0,       32'h0,        2, 2));
        vecs.push_back(mkv(1, 0, 32'h400,     32'h0,        0, 64'h0, 1, 32'hAAAAAAAA, 0, 0, 32'h0,       32'h0,        3, 2));
        vecs.push_back(mkv(0, 0, 32'h0,       32'h0,        0, 64'h0, 1, 32'h0,        0, 0, 32'h0,       32'h0,        4, 2));
        vecs.push_back(mkv(1, 1, 32'h400,     32'h55550000, 0, 64'h0, 0, 32'h0,        0, 0, 32'h0,       32'h0,        4, 2));
        vecs.push_back(mkv(1, 1, 32'h400,     32'h55550000, 1, 64'h0, 1, 32'h0,        0, 1, 32'h400,     32'h55550000, 4, 2));
        vecs.push_back(mkv(1, 0, 32'h400,     32'h0,        0, 64'h0, 1, 32'h55550000, 0, 0, 32'h0,       32'h0,        4, 2));
        vecs.push_back(mkv(0, 0, 32'h0,       32'h0,        1, 64'h0, 1, 32'h0,        0, 0, 32'h0,       32'h0,        5, 2));

        for (int i = 0; i < vecs.size(); i++) begin
            v = vecs[i];
            rd_en = v.rd; wr_en = v.wr; addr = v.a; wdata = v.wd;
            mem_ready = v.mr; mem_rdata = v.ml;
            @(negedge clk);
            check($sformatf("row%0d_ready", i), {31'd0, ready}, {31'd0, v.e_ready});
            check($sformatf("row%0d_rdata", i), rdata, v.e_rdata);
            check($sformatf("row%0d_mem_rd_en", i), {31'd0, mem_rd_en}, {31'd0, v.e_mrd});
            check($sformatf("row%0d_mem_wr_en", i), {31'd0, mem_wr_en}, {31'd0, v.e_mwr});
            check($sformatf("row%0d_hit_cnt", i), {16'd0, hit_cnt}, {16'd0, v.e_hit});
            check($sformatf("row%0d_miss_cnt", i), {16'd0, miss_cnt}, {16'd0, v.e_miss});
            if (v.e_mrd || v.e_mwr)
                check($sformatf("row%0d_mem_addr", i), mem_addr, v.e_maddr);
            if (v.e_mwr)
                check($sformatf("row%0d_mem_wdata", i), mem_wdata, v.e_mwdata);
            step();
        end
        rd_en = 1'b0; wr_en = 1'b0; mem_ready = 1'b0;

        // LRU replacement within set 0.
        do_reset();
        read_op(32'h000, 1'b0);
        read_op(32'h200, 1'b0);
        read_op(32'h000, 1'b1);
        read_op(32'h400, 1'b0);
        read_op(32'h000, 1'b1);
        read_op(32'h200, 1'b0);
        @(negedge clk);
        check("lru_hit_cnt", {16'd0, hit_cnt}, 32'd2);
        check("lru_miss_cnt", {16'd0, miss_cnt}, 32'd4);
        step();

        // Reset while a line fill is outstanding.
        read_op(32'h000, 1'b1);
        rd_en = 1'b1; addr = 32'h600; mem_rdata = mk_line(32'h600); mem_ready = 1'b0;
        step();
        @(negedge clk);
        check("abort_mem_rd_before_rst", {31'd0, mem_rd_en}, 32'd1);
        rst = 1'b1; rd_en = 1'b0;
        step();
        rst = 1'b0; mem_ready = 1'b1;
        @(negedge clk);
        check("abort_mem_rd_en", {31'd0, mem_rd_en}, 32'd0);
        check("abort_ready", {31'd0, ready}, 32'd1);
        check("abort_rdata", rdata, 32'd0);
        check("abort_hit_cnt", {16'd0, hit_cnt}, 32'd0);
        check("abort_miss_cnt", {16'd0, miss_cnt}, 32'd0);
        step();
        mem_ready = 1'b0;
        read_op(32'h000, 1'b0);
        @(negedge clk);
        check("abort_remiss_cnt", {16'd0, miss_cnt}, 32'd1);
        step();

        // Direct-mapped configuration: conflicting lines always miss.
        u1_addrs[0] = 32'h000; u1_addrs[1] = 32'h200; u1_addrs[2] = 32'h000;
        for (int k = 0; k < 3; k++) begin
            l1 = mk_line(u1_addrs[k]);
            u1_rd_en = 1'b1; u1_addr = u1_addrs[k]; u1_mem_rdata = l1; u1_mem_ready = 1'b0;
            @(negedge clk);
            check($sformatf("w1_stall_%0d", k), {31'd0, u1_ready}, 32'd0);
            step();
            @(negedge clk);
            check($sformatf("w1_mem_rd_%0d", k), {31'd0, u1_mem_rd_en}, 32'd1);
            u1_mem_ready = 1'b1;
            #1;
            check($sformatf("w1_rdata_%0d", k), u1_rdata, l1[31:0]);
            step();
            u1_rd_en = 1'b0; u1_mem_ready = 1'b0;
        end
        @(negedge clk);
        check("w1_miss_cnt", {16'd0, u1_miss_cnt}, 32'd3);
        check("w1_hit_cnt", {16'd0, u1_hit_cnt}, 32'd0);
        step();

        // Hold a hit so hit_cnt climbs to its saturation point.
        u1_rd_en = 1'b1; u1_addr = 32'h000;
        repeat (65534) @(posedge clk);
        @(negedge clk);
        check("sat_hit_cnt_fffe", {16'd0, u1_hit_cnt}, 32'h0000_FFFE);
        repeat (10) @(posedge clk);
        @(negedge clk);
        check("sat_hit_cnt_ffff", {16'd0, u1_hit_cnt}, 32'h0000_FFFF);
        check("sat_miss_cnt", {16'd0, u1_miss_cnt}, 32'd3);
        check("sat_ready", {31'd0, u1_ready}, 32'd1);
        u1_rd_en = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/cache_nway.md
CACHE_NWAY -- requirements
Module: cache_nway

Interface
REQ-001 SHALL have parameter SETS, default 64, number of sets (power of 2, 2..1024).
REQ-002 SHALL have parameter WAYS, default 2, associativity (1 or 2 only).
REQ-003 SHALL have parameter LINE_WORDS, default 2, 32-bit words per line (power of 2, 1..8).
REQ-004 SHALL have a single clock and a synchronous, active-high reset: clk input 1 (all state on rising edge); rst input 1.
REQ-005 SHALL have ports rd_en input 1 and wr_en input 1: CPU read and write request, held stable while ready=0.
REQ-006 SHALL have ports addr input 32 and wdata input 32: CPU byte address and write data.
REQ-007 SHALL have ports rdata output 32 and ready output 1: read result, and request completes this cycle (0 = stall pipeline).
REQ-008 SHALL have ports mem_rd_en output 1 and mem_wr_en output 1: backing-store line read and word write request.
REQ-009 SHALL have ports mem_addr output 32 and mem_wdata output 32: backing-store address and write word.
REQ-010 SHALL have ports mem_rdata input 32*LINE_WORDS and mem_ready input 1: returned line (word 0 in LSBs), and backing-store transaction done.
REQ-011 SHALL have ports hit_cnt output 16 and miss_cnt output 16: read hit and read miss counters.

Function
REQ-012 SHALL decode addr as: bits[1:0] ignored; word offset = next log2(LINE_WORDS) bits; index = next log2(SETS) bits; tag = remaining upper bits.
REQ-013 SHALL hold per way per set: valid bit, tag, LINE_WORDS data words; per set, one LRU bit naming the least-recently-used way (ignored when WAYS=1).
REQ-014 SHALL implement FSM states IDLE, RD_MISS, WR_THRU.
REQ-015 SHALL, in IDLE with no request, drive ready=1 and mem_rd_en=mem_wr_en=0.
REQ-016 SHALL treat rd_en=wr_en=1 as a write.
REQ-017 SHALL, in IDLE on a read hit, drive ready=1 and rdata=hit word combinationally in the same cycle, set LRU to the other way, increment hit_cnt, and stay in IDLE.
REQ-018 SHALL, in IDLE on a read miss, drive ready=0, increment miss_cnt once, and go to RD_MISS.
REQ-019 SHALL, in RD_MISS, drive mem_rd_en=1 and mem_addr=addr with word-offset and bits[1:0] cleared, holding both until mem_ready.
REQ-020 SHALL, in the mem_ready cycle of RD_MISS, drive ready=1 and rdata=selected word of mem_rdata, and at that edge fill the victim way, set valid and tag, update LRU, and return to IDLE.
REQ-021 SHALL choose the victim as the lowest-numbered invalid way if any, else the LRU way.
REQ-022 SHALL, in IDLE on a write, drive ready=0 and go to WR_THRU (write-through, no write-allocate).
REQ-023 SHALL, in WR_THRU, drive mem_wr_en=1, mem_addr=addr and mem_wdata=wdata until mem_ready.
REQ-024 SHALL, in the mem_ready cycle of WR_THRU, drive ready=1, and at that edge update the cached word and LRU on a hit (no change on a miss), then return to IDLE.
REQ-025 SHALL ignore mem_ready outside RD_MISS/WR_THRU; mem_rd_en and mem_wr_en SHALL never both be 1.
REQ-026 SHALL saturate hit_cnt and miss_cnt at 0xFFFF; writes SHALL not change either counter.
REQ-027 SHALL drive rdata=0 when not completing a read.

Reset
REQ-028 SHALL, on rst=1 at a clock edge, clear all valid bits and LRU bits, set state to IDLE and hit_cnt=miss_cnt=0; outputs after reset: ready=1, mem_rd_en=0, mem_wr_en=0, rdata=0.
REQ-029 SHALL let reset during RD_MISS/WR_THRU abort the transaction with no cache update; a later mem_ready SHALL be ignored.

Verification
REQ-030 SHALL cover read miss then hit (defaults): read 0x400, mem_ready 3 cycles after mem_rd_en with mem_rdata={0xBBBBBBBB,0xAAAAAAAA} -> mem_addr=0x400, ready=1 with rdata=0xAAAAAAAA; then read 0x404 -> same-cycle ready, rdata=0xBBBBBBBB, hit_cnt=1, miss_cnt=1.
REQ-031 SHALL cover LRU replacement: fill 0x000 and 0x200 (set 0), read 0x000, read 0x400 -> 0x200 evicted; read 0x000 hits, read 0x200 misses.
REQ-032 SHALL cover write hit: write 0x404=0x12345678 after REQ-030 -> mem_wr_en, mem_addr=0x404 until mem_ready; a later read 0x404 hits with 0x12345678 and no mem_rd_en.
REQ-033 SHALL cover write miss: write 0x800 -> write-through only; a later read 0x800 misses (miss_cnt increments).
REQ-034 SHALL cover reset mid-miss: rst=1 while in RD_MISS -> next cycle mem_rd_en=0, ready=1, counters 0; a prior hit address now misses.
REQ-035 SHALL cover WAYS=1: reads 0x000, 0x200, 0x000 -> three misses, miss_cnt=3.
